// File: rtl/bullet_pool_pkg.sv
// rtl/bullet_pool_pkg.sv - shared constants, slot state encoding and allocator helper for bullet_pool
//
// Purpose: fixed-point shift, coordinate widths, slot index width, per-slot
//   IDLE/ACTIVE encoding and the lowest-set-bit search used to pick a free slot.
// Ports: none (package).
package bullet_pool_pkg;

  localparam int FRAC   = 4;   // fractional bits of the 1/16 px fixed point
  localparam int X_W    = 10;  // pixel x width
  localparam int Y_W    = 9;   // pixel y width
  localparam int X16_W  = 14;  // x in 1/16 px
  localparam int Y16_W  = 13;  // y and vy in 1/16 px
  localparam int VX_W   = 8;   // unsigned vx in 1/16 px per tick
  localparam int SLOT_W = 4;   // slot index width (up to 16 slots)

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } slot_state_t;

  // Index of the lowest set bit of v; the extra MSB is set when v is all zero.
  function automatic logic [SLOT_W:0] lowest_set(input logic [15:0] v);
    lowest_set = {1'b1, {SLOT_W{1'b0}}};
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest_set = {1'b0, SLOT_W'(i)};
    end
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// rtl/bullet_pool_if.sv - fire request / acknowledge bundle between game logic and bullet_pool
//
// Purpose: groups the launch request, its launch values and the pool's reply.
// Signals:
//   fire        request one bullet this tick
//   x_din       launch x, pixels
//   y_din       launch y, pixels
//   vx_din_16x  launch vx, unsigned, 1/16 px per tick
//   vy_din_16x  launch vy, signed, 1/16 px per tick
//   fire_ack    registered, 1 for one tick after an accepted fire
//   fire_slot   registered, slot claimed by the last accepted fire
//   full        combinational, every slot active (fire is dropped)
// Modports: master = requester, slave = bullet_pool.
interface bullet_pool_if;
  import bullet_pool_pkg::*;

  logic                    fire;
  logic [X_W-1:0]          x_din;
  logic [Y_W-1:0]          y_din;
  logic [VX_W-1:0]         vx_din_16x;
  logic signed [Y16_W-1:0] vy_din_16x;
  logic                    fire_ack;
  logic [SLOT_W-1:0]       fire_slot;
  logic                    full;

  modport master (
    output fire, x_din, y_din, vx_din_16x, vy_din_16x,
    input  fire_ack, fire_slot, full
  );

  modport slave (
    input  fire, x_din, y_din, vx_din_16x, vy_din_16x,
    output fire_ack, fire_slot, full
  );

endinterface

// File: rtl/bullet_pool_slot.sv
// rtl/bullet_pool_slot.sv - one bullet: IDLE/ACTIVE FSM plus fixed-point position/velocity datapath
//
// Purpose: loads launch values on i_load while idle, moves every active tick,
//   retires when its current pixel position is off the playfield.
//   Optional gravity on vy when BULLET_GRAVITY_EN is defined.
// Ports:
//   clk_100Hz, rst   game tick clock, synchronous active-high reset
//   i_load           claim this slot this tick (only honoured while idle)
//   i_x, i_y         launch position, pixels
//   i_vx, i_vy       launch velocity, 1/16 px per tick
//   o_active         current state is ACTIVE
//   o_active_nxt     state after this edge will be ACTIVE
//   o_x, o_y         current pixel position
module bullet_pool_slot
  import bullet_pool_pkg::*;
#(
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 400,
  parameter int G_16X      = 2,
  parameter int VY_MAX_16X = 1023
) (
  input  logic                    clk_100Hz,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic [X_W-1:0]          i_x,
  input  logic [Y_W-1:0]          i_y,
  input  logic [VX_W-1:0]         i_vx,
  input  logic signed [Y16_W-1:0] i_vy,
  output logic                    o_active,
  output logic                    o_active_nxt,
  output logic [X_W-1:0]          o_x,
  output logic [Y_W-1:0]          o_y
);

  slot_state_t             r_state, w_state_nxt;
  logic [X16_W-1:0]        r_x_16x;
  logic [Y16_W-1:0]        r_y_16x;
  logic [VX_W-1:0]         r_vx;
  logic signed [Y16_W-1:0] r_vy, w_vy_nxt;
  logic                    w_off_field;
  logic                    w_move;

  assign o_x = r_x_16x[X16_W-1:FRAC];
  assign o_y = r_y_16x[Y16_W-1:FRAC];

  // An upward bullet that wraps below y=0 lands at a large y and retires here too.
  assign w_off_field = (int'(o_x) >= X_MAX) || (int'(o_y) >= Y_MAX);

  always_ff @(posedge clk_100Hz) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_load)      w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_off_field) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_active     = (r_state == S_ACTIVE);
    o_active_nxt = (w_state_nxt == S_ACTIVE);
    w_move       = (r_state == S_ACTIVE);
  end

`ifdef BULLET_GRAVITY_EN
  // One extra bit so vy + G never overflows before the signed clamp.
  localparam logic signed [Y16_W:0] G_EXT   = G_16X[Y16_W:0];
  localparam logic signed [Y16_W:0] VY_CEIL = VY_MAX_16X[Y16_W:0];
  logic signed [Y16_W:0] w_vy_sum;

  always_comb begin
    w_vy_sum = $signed({r_vy[Y16_W-1], r_vy}) + G_EXT;
    w_vy_nxt = (w_vy_sum > VY_CEIL) ? VY_CEIL[Y16_W-1:0] : w_vy_sum[Y16_W-1:0];
  end
`else
  // Gravity constants only matter when BULLET_GRAVITY_EN is defined.
  logic [31:0] w_cfg_unused;
  assign w_cfg_unused = 32'(G_16X) ^ 32'(VY_MAX_16X);
  assign w_vy_nxt = r_vy;
`endif

  // Position uses the old vy; vy (gravity) updates in the same edge.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      r_x_16x <= '0;
      r_y_16x <= '0;
      r_vx    <= '0;
      r_vy    <= '0;
    end else if (i_load && (r_state == S_IDLE)) begin
      r_x_16x <= {i_x, 4'h0};
      r_y_16x <= {i_y, 4'h0};
      r_vx    <= i_vx;
      r_vy    <= i_vy;
    end else if (w_move) begin
      r_x_16x <= r_x_16x + X16_W'(r_vx);
      r_y_16x <= r_y_16x + $unsigned(r_vy);
      r_vy    <= w_vy_nxt;
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - pool of N_SLOTS bullets with lowest-free-slot allocation
//
// Purpose: one fire per tick claims the lowest-index idle slot; slots move at
//   100 Hz in 1/16 px fixed point and retire when off the playfield.
//   Optional macro: BULLET_GRAVITY_EN (vy += G_16X per tick, clamped at VY_MAX_16X).
// Ports:
//   clk_100Hz, rst    game tick clock, synchronous active-high reset
//   bus (slave)       fire request, launch values, fire_ack/fire_slot/full
//   o_active          registered per-slot active flags
//   o_active_count    registered popcount of o_active
//   o_x_flat          pixel x of slot i at [i*10 +: 10]
//   o_y_flat          pixel y of slot i at [i*9 +: 9]
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int N_SLOTS    = 8,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 400,
  parameter int G_16X      = 2,
  parameter int VY_MAX_16X = 1023
) (
  input  logic                     clk_100Hz,
  input  logic                     rst,
  bullet_pool_if.slave             bus,
  output logic [N_SLOTS-1:0]       o_active,
  output logic [4:0]               o_active_count,
  output logic [N_SLOTS*X_W-1:0]   o_x_flat,
  output logic [N_SLOTS*Y_W-1:0]   o_y_flat
);

  logic [N_SLOTS-1:0] w_active_nxt;
  logic [N_SLOTS-1:0] w_load;
  logic [SLOT_W:0]    w_pick;
  logic               w_accept;
  logic [4:0]         w_count_nxt;
  logic               r_fire_ack;
  logic [SLOT_W-1:0]  r_fire_slot;
  logic [4:0]         r_active_count;

  // Free slots are sampled before the edge, so a slot retiring this edge is not reusable yet.
  assign w_pick   = lowest_set(16'(~o_active));
  assign bus.full = &o_active;
  assign w_accept = bus.fire && !bus.full;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_load[i] = w_accept && (w_pick == (SLOT_W + 1)'(i));
    end
  end

  // Count the post-edge state so active_count moves on the same edge as active.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_count_nxt = w_count_nxt + 5'(w_active_nxt[i]);
    end
  end

  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      r_fire_ack     <= 1'b0;
      r_fire_slot    <= '0;
      r_active_count <= '0;
    end else begin
      r_fire_ack     <= w_accept;
      if (w_accept) r_fire_slot <= w_pick[SLOT_W-1:0];
      r_active_count <= w_count_nxt;
    end
  end

  assign bus.fire_ack   = r_fire_ack;
  assign bus.fire_slot  = r_fire_slot;
  assign o_active_count = r_active_count;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    bullet_pool_slot #(
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX),
      .G_16X      (G_16X),
      .VY_MAX_16X (VY_MAX_16X)
    ) u_slot (
      .clk_100Hz    (clk_100Hz),
      .rst          (rst),
      .i_load       (w_load[g]),
      .i_x          (bus.x_din),
      .i_y          (bus.y_din),
      .i_vx         (bus.vx_din_16x),
      .i_vy         (bus.vy_din_16x),
      .o_active     (o_active[g]),
      .o_active_nxt (w_active_nxt[g]),
      .o_x          (o_x_flat[g*X_W +: X_W]),
      .o_y          (o_y_flat[g*Y_W +: Y_W])
    );
  end

endmodule

// File: tb/tb_bullet_pool.sv
// tb/tb_bullet_pool.sv - self-checking bench for bullet_pool (directed scenarios plus randomized model compare)
module tb_bullet_pool;

  localparam int N   = 8;
  localparam int XM  = 640;
  localparam int YM  = 400;
  localparam int G   = 2;
  localparam int VYM = 1023;

  logic clk_100Hz = 1'b0;
  logic rst;
  always #5 clk_100Hz = ~clk_100Hz;

  bullet_pool_if bus ();
  logic [N-1:0]    o_active;
  logic [4:0]      o_active_count;
  logic [N*10-1:0] o_x_flat;
  logic [N*9-1:0]  o_y_flat;

  bullet_pool #(
    .N_SLOTS(N), .X_MAX(XM), .Y_MAX(YM), .G_16X(G), .VY_MAX_16X(VYM)
  ) dut (
    .clk_100Hz      (clk_100Hz),
    .rst            (rst),
    .bus            (bus),
    .o_active       (o_active),
    .o_active_count (o_active_count),
    .o_x_flat       (o_x_flat),
    .o_y_flat       (o_y_flat)
  );

  // Reference model: plain integers per bullet, positions in 1/16 px.
  int m_act [N];
  int m_x   [N];
  int m_y   [N];
  int m_vx  [N];
  int m_vy  [N];
  int m_ack, m_slot, m_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Drive one tick's inputs, advance the model across the edge, return at the next negedge.
  task automatic step(input logic f, input int x, input int y, input int vx, input int vy, input logic r);
    int fs;
    bit gone;
    bus.fire = f;
    bus.x_din = x[9:0];
    bus.y_din = y[8:0];
    bus.vx_din_16x = vx[7:0];
    bus.vy_din_16x = vy[12:0];
    rst = r;
    @(posedge clk_100Hz);
    if (r) begin
      for (int s = 0; s < N; s++) begin
        m_act[s] = 0; m_x[s] = 0; m_y[s] = 0; m_vx[s] = 0; m_vy[s] = 0;
      end
      m_ack = 0; m_slot = 0;
    end else begin
      fs = -1;
      for (int s = N - 1; s >= 0; s--) if (m_act[s] == 0) fs = s;
      for (int s = 0; s < N; s++) begin
        if (m_act[s] != 0) begin
          gone = ((m_x[s] / 16) >= XM) || ((m_y[s] / 16) >= YM);
          m_x[s] = (m_x[s] + m_vx[s]) & 16383;
          m_y[s] = (m_y[s] + m_vy[s]) & 8191;
`ifdef BULLET_GRAVITY_EN
          m_vy[s] = (m_vy[s] + G > VYM) ? VYM : m_vy[s] + G;
`endif
          if (gone) m_act[s] = 0;
        end
      end
      if (f && fs >= 0) begin
        m_act[fs] = 1;
        m_x[fs] = (x & 1023) * 16;
        m_y[fs] = (y & 511) * 16;
        m_vx[fs] = vx & 255;
        m_vy[fs] = vy;
        m_ack = 1;
        m_slot = fs;
      end else begin
        m_ack = 0;
      end
    end
    m_cnt = 0;
    for (int s = 0; s < N; s++) m_cnt += m_act[s];
    @(negedge clk_100Hz);
    bus.fire = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 100, 100, 1, 1, 1'b1);
    vectors++;
    if (o_active !== '0) begin miscompares++; $display("FAIL reset_active: got %h expected 0", o_active); end
    vectors++;
    if (o_active_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", o_active_count); end
    vectors++;
    if (bus.fire_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", bus.fire_ack); end
    vectors++;
    if (bus.fire_slot !== 4'd0) begin miscompares++; $display("FAIL reset_slot: got %0d expected 0", bus.fire_slot); end
    vectors++;
    if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
  endtask

  task automatic test_single;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 100, 200, 16, -32, 1'b0);
    vectors++;
    if (bus.fire_ack !== 1'b1 || bus.fire_slot !== 4'd0) begin
      miscompares++; $display("FAIL single_ack: got ack=%b slot=%0d expected ack=1 slot=0", bus.fire_ack, bus.fire_slot);
    end
    vectors++;
    if (o_active !== 8'h01 || o_x_flat[9:0] !== 10'd100 || o_y_flat[8:0] !== 9'd200) begin
      miscompares++; $display("FAIL single_launch: got act=%h x=%0d y=%0d expected act=01 x=100 y=200", o_active, o_x_flat[9:0], o_y_flat[8:0]);
    end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (bus.fire_ack !== 1'b0) begin miscompares++; $display("FAIL single_ack_pulse: got %b expected 0", bus.fire_ack); end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_x_flat[9:0] !== 10'd102 || o_y_flat[8:0] !== 9'd196) begin
      miscompares++; $display("FAIL single_move: got x=%0d y=%0d expected x=102 y=196", o_x_flat[9:0], o_y_flat[8:0]);
    end
  endtask

  task automatic test_fill;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < N; i++) begin
      step(1'b1, 20 * i, 30 + i, 0, 0, 1'b0);
      vectors++;
      if (bus.fire_ack !== 1'b1 || int'(bus.fire_slot) != i) begin
        miscompares++; $display("FAIL fill_slot%0d: got ack=%b slot=%0d expected ack=1 slot=%0d", i, bus.fire_ack, bus.fire_slot, i);
      end
    end
    vectors++;
    if (bus.full !== 1'b1 || o_active_count !== 5'd8) begin
      miscompares++; $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=8", bus.full, o_active_count);
    end
    step(1'b1, 300, 300, 5, 5, 1'b0);
    vectors++;
    if (bus.fire_ack !== 1'b0 || o_active !== 8'hff || bus.fire_slot !== 4'd7 || o_active_count !== 5'd8) begin
      miscompares++; $display("FAIL fill_drop: got ack=%b act=%h slot=%0d count=%0d expected ack=0 act=ff slot=7 count=8",
                              bus.fire_ack, o_active, bus.fire_slot, o_active_count);
    end
    vectors++;
    if (o_x_flat[9:0] !== 10'd0 || o_y_flat[8:0] !== 9'd30 || o_x_flat[70 +: 10] !== 10'd140) begin
      miscompares++; $display("FAIL fill_hold: got x0=%0d y0=%0d x7=%0d expected 0 30 140", o_x_flat[9:0], o_y_flat[8:0], o_x_flat[70 +: 10]);
    end
  endtask

  task automatic test_x_edge;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 639, 100, 16, 0, 1'b0);
    vectors++;
    if (o_active !== 8'h01 || o_x_flat[9:0] !== 10'd639) begin
      miscompares++; $display("FAIL xedge_launch: got act=%h x=%0d expected act=01 x=639", o_active, o_x_flat[9:0]);
    end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_active !== 8'h01 || o_x_flat[9:0] !== 10'd640) begin
      miscompares++; $display("FAIL xedge_move: got act=%h x=%0d expected act=01 x=640", o_active, o_x_flat[9:0]);
    end
    step(1'b1, 50, 50, 0, 0, 1'b0);
    vectors++;
    if (o_active !== 8'h02 || bus.fire_slot !== 4'd1 || bus.fire_ack !== 1'b1 || o_active_count !== 5'd1) begin
      miscompares++; $display("FAIL xedge_retire: got act=%h slot=%0d ack=%b count=%0d expected act=02 slot=1 ack=1 count=1",
                              o_active, bus.fire_slot, bus.fire_ack, o_active_count);
    end
    step(1'b1, 60, 60, 0, 0, 1'b0);
    vectors++;
    if (bus.fire_slot !== 4'd0 || o_active !== 8'h03) begin
      miscompares++; $display("FAIL xedge_reuse: got slot=%0d act=%h expected slot=0 act=03", bus.fire_slot, o_active);
    end
  endtask

  task automatic test_y_wrap;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    step(1'b1, 5, 0, 0, -16, 1'b0);
    vectors++;
    if (o_y_flat[8:0] !== 9'd0) begin miscompares++; $display("FAIL ywrap_launch: got y=%0d expected 0", o_y_flat[8:0]); end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_y_flat[8:0] !== 9'd511 || o_active !== 8'h01) begin
      miscompares++; $display("FAIL ywrap_wrap: got y=%0d act=%h expected y=511 act=01", o_y_flat[8:0], o_active);
    end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_active !== 8'h00 || o_active_count !== 5'd0) begin
      miscompares++; $display("FAIL ywrap_retire: got act=%h count=%0d expected act=00 count=0", o_active, o_active_count);
    end
  endtask

  task automatic test_reset_midflight;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 10 + i, 10, 0, 0, 1'b0);
    vectors++;
    if (o_active_count !== 5'd3) begin miscompares++; $display("FAIL mid_count3: got %0d expected 3", o_active_count); end
    step(1'b1, 200, 200, 0, 0, 1'b1);
    vectors++;
    if (o_active !== 8'h00 || bus.fire_ack !== 1'b0 || o_active_count !== 5'd0) begin
      miscompares++; $display("FAIL mid_reset: got act=%h ack=%b count=%0d expected act=00 ack=0 count=0", o_active, bus.fire_ack, o_active_count);
    end
  endtask

`ifdef BULLET_GRAVITY_EN
  task automatic test_gravity;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    // vy starts at 0: offsets 0,2,6,12,20 after successive moves -> +1 px after 5 moves
    step(1'b1, 0, 100, 0, 0, 1'b0);
    // vy starts near the ceiling: 1020,1022,1023,1023,1023 -> 5111 (px 319), unclamped would reach px 320
    step(1'b1, 0, 0, 0, 1020, 1'b0);
    for (int t = 0; t < 4; t++) step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_y_flat[8:0] !== 9'd101) begin miscompares++; $display("FAIL grav_accel: got y=%0d expected 101", o_y_flat[8:0]); end
    step(1'b0, 0, 0, 0, 0, 1'b0);
    vectors++;
    if (o_y_flat[9 +: 9] !== 9'd319) begin miscompares++; $display("FAIL grav_clamp: got y=%0d expected 319", o_y_flat[9 +: 9]); end
  endtask
`endif

  task automatic test_random;
    logic [N-1:0] exp_act;
    logic f, r;
    int vy;
    step(1'b0, 0, 0, 0, 0, 1'b1);
    for (int t = 0; t < 400; t++) begin
      f = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 99) == 0);
      vy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191)) - 4096 : int'($urandom_range(0, 400)) - 200;
      vectors++;
      if (bus.full !== (m_cnt == N)) begin
        miscompares++; $display("FAIL rnd_full t=%0d: got %b expected %0d", t, bus.full, m_cnt == N);
      end
      step(f, $urandom_range(0, 700), $urandom_range(0, 420), $urandom_range(0, 255), vy, r);
      for (int s = 0; s < N; s++) exp_act[s] = (m_act[s] != 0);
      vectors++;
      if (o_active !== exp_act || o_active_count !== 5'(m_cnt)) begin
        miscompares++; $display("FAIL rnd_active t=%0d: got act=%h count=%0d expected act=%h count=%0d", t, o_active, o_active_count, exp_act, m_cnt);
      end
      vectors++;
      if (bus.fire_ack !== 1'(m_ack) || bus.fire_slot !== 4'(m_slot)) begin
        miscompares++; $display("FAIL rnd_ack t=%0d: got ack=%b slot=%0d expected ack=%0d slot=%0d", t, bus.fire_ack, bus.fire_slot, m_ack, m_slot);
      end
      for (int s = 0; s < N; s++) begin
        if (m_act[s] != 0) begin
          vectors++;
          if (o_x_flat[s*10 +: 10] !== 10'(m_x[s] / 16) || o_y_flat[s*9 +: 9] !== 9'(m_y[s] / 16)) begin
            miscompares++; $display("FAIL rnd_pos t=%0d slot=%0d: got x=%0d y=%0d expected x=%0d y=%0d",
                                    t, s, o_x_flat[s*10 +: 10], o_y_flat[s*9 +: 9], m_x[s] / 16, m_y[s] / 16);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.fire = 1'b0;
    bus.x_din = '0;
    bus.y_din = '0;
    bus.vx_din_16x = '0;
    bus.vy_din_16x = '0;
    @(negedge clk_100Hz);
    test_reset();
    test_single();
    test_fill();
    test_x_edge();
    test_y_wrap();
    test_reset_midflight();
`ifdef BULLET_GRAVITY_EN
    test_gravity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
